// File: rtl/fios_mm_seq_ctrl.sv
// Operand/result sequencer around a FIOS Montgomery core, with chained squaring.
// Optional final subtraction of P is built when FIOS_SEQ_FINAL_SUB_EN is defined.
//
// state  | meaning
// IDLE   | one-cycle rest after reset or a finished result stream
// LOAD   | accept S word beats of A, B, P from the host
// START  | single-cycle core start pulse, core-side pointers cleared
// RUN    | core running; serve operand windows/words, capture result words
// FEED   | copy result into A and B for the next squaring
// FINSUB | word-serial RES-P into D buffer (optional build only)
// DRAIN  | stream RES (or D) to the host
module fios_mm_seq_ctrl #(
   parameter int WORD_W = 17,
   parameter int S      = 8,
   parameter int PE_NB  = 8,
   parameter int CNT_W  = 8
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    op_valid_i,
   output logic                    op_ready_o,
   input  logic [WORD_W-1:0]       op_a_i,
   input  logic [WORD_W-1:0]       op_b_i,
   input  logic [WORD_W-1:0]       op_p_i,
   input  logic [CNT_W-1:0]        cfg_sq_i,
   output logic                    core_start_o,
   output logic [PE_NB*WORD_W-1:0] core_a_o,
   output logic [WORD_W-1:0]       core_b_o,
   output logic [WORD_W-1:0]       core_p_o,
   input  logic                    core_a_shift_i,
   input  logic                    core_b_fetch_i,
   input  logic                    core_p_fetch_i,
   input  logic                    core_res_push_i,
   input  logic [WORD_W-1:0]       core_res_i,
   input  logic                    core_done_i,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic [WORD_W-1:0]       res_word_o,
   output logic                    res_last_o,
   output logic                    busy_o,
   output logic                    err_o
);
   localparam int LP_W = (S > 1) ? $clog2(S) : 1;
   localparam int RP_W = $clog2(S + 1);
   localparam int AW_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_START, ST_RUN, ST_FEED,
`ifdef FIOS_SEQ_FINAL_SUB_EN
      ST_FINSUB,
`endif
      ST_DRAIN
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] a_buf   [S];
   logic [WORD_W-1:0] b_buf   [S];
   logic [WORD_W-1:0] p_buf   [S];
   logic [WORD_W-1:0] res_buf [S];
   logic [LP_W-1:0]   ld_ptr, b_ptr, p_ptr, out_ptr;
   logic [RP_W-1:0]   res_ptr;
   logic [AW_W-1:0]   a_win;
   logic [CNT_W-1:0]  sq_cnt;

`ifdef FIOS_SEQ_FINAL_SUB_EN
   logic [WORD_W-1:0] d_buf [S];
   logic              borrow, use_d;
   logic [WORD_W:0]   sub_full;

   assign sub_full = {1'b0, res_buf[out_ptr]} - {1'b0, p_buf[out_ptr]}
                     - {{WORD_W{1'b0}}, borrow};
   assign res_word_o = use_d ? d_buf[out_ptr] : res_buf[out_ptr];
`else
   assign res_word_o = res_buf[out_ptr];
`endif

   // Window k lane carries A[a_win*PE_NB+k]; lanes past the last word stay zero.
   always_comb begin
      core_a_o = '0;
      for (int k = 0; k < PE_NB; k++)
         for (int j = 0; j < S; j++)
            if (int'(a_win) * PE_NB + k == j)
               core_a_o[k*WORD_W +: WORD_W] = a_buf[j];
   end

   assign core_b_o   = b_buf[b_ptr];
   assign core_p_o   = p_buf[p_ptr];
   assign res_last_o = res_valid_o && (out_ptr == LP_W'(S - 1));
   assign busy_o     = (state != ST_IDLE);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state        <= ST_IDLE;
         ld_ptr       <= '0;
         a_win        <= '0;
         b_ptr        <= '0;
         p_ptr        <= '0;
         res_ptr      <= '0;
         out_ptr      <= '0;
         sq_cnt       <= '0;
         op_ready_o   <= 1'b0;
         core_start_o <= 1'b0;
         res_valid_o  <= 1'b0;
         err_o        <= 1'b0;
`ifdef FIOS_SEQ_FINAL_SUB_EN
         borrow       <= 1'b0;
         use_d        <= 1'b0;
`endif
      end else begin
         core_start_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               ld_ptr     <= '0;
               op_ready_o <= 1'b1;
               state      <= ST_LOAD;
            end
            ST_LOAD: begin
               if (op_valid_i && op_ready_o) begin
                  a_buf[ld_ptr] <= op_a_i;
                  b_buf[ld_ptr] <= op_b_i;
                  p_buf[ld_ptr] <= op_p_i;
                  if (ld_ptr == '0)
                     sq_cnt <= cfg_sq_i;
                  if (ld_ptr == LP_W'(S - 1)) begin
                     ld_ptr       <= '0;
                     op_ready_o   <= 1'b0;
                     core_start_o <= 1'b1;
                     state        <= ST_START;
                  end else begin
                     ld_ptr <= ld_ptr + LP_W'(1);
                  end
               end
            end
            ST_START: begin
               a_win   <= '0;
               b_ptr   <= '0;
               p_ptr   <= '0;
               res_ptr <= '0;
               state   <= ST_RUN;
            end
            ST_RUN: begin
               if (core_a_shift_i)
                  a_win <= a_win + AW_W'(1);
               if (core_b_fetch_i)
                  b_ptr <= (b_ptr == LP_W'(S - 1)) ? '0 : b_ptr + LP_W'(1);
               if (core_p_fetch_i)
                  p_ptr <= (p_ptr == LP_W'(S - 1)) ? '0 : p_ptr + LP_W'(1);
               if (core_res_push_i) begin
                  if (res_ptr == RP_W'(S)) begin
                     err_o <= 1'b1;
                  end else begin
                     res_buf[res_ptr[LP_W-1:0]] <= core_res_i;
                     res_ptr                    <= res_ptr + RP_W'(1);
                  end
               end
               if (core_done_i) begin
                  if (res_ptr != RP_W'(S))
                     err_o <= 1'b1;
                  out_ptr <= '0;
                  if (sq_cnt != '0) begin
                     state <= ST_FEED;
                  end else begin
`ifdef FIOS_SEQ_FINAL_SUB_EN
                     borrow <= 1'b0;
                     state  <= ST_FINSUB;
`else
                     res_valid_o <= 1'b1;
                     state       <= ST_DRAIN;
`endif
                  end
               end
            end
            ST_FEED: begin
               a_buf        <= res_buf;
               b_buf        <= res_buf;
               sq_cnt       <= sq_cnt - CNT_W'(1);
               core_start_o <= 1'b1;
               state        <= ST_START;
            end
`ifdef FIOS_SEQ_FINAL_SUB_EN
            ST_FINSUB: begin
               d_buf[out_ptr] <= sub_full[WORD_W-1:0];
               borrow         <= sub_full[WORD_W];
               if (out_ptr == LP_W'(S - 1)) begin
                  use_d       <= ~sub_full[WORD_W];
                  out_ptr     <= '0;
                  res_valid_o <= 1'b1;
                  state       <= ST_DRAIN;
               end else begin
                  out_ptr <= out_ptr + LP_W'(1);
               end
            end
`endif
            ST_DRAIN: begin
               if (res_valid_o && res_ready_i) begin
                  if (out_ptr == LP_W'(S - 1)) begin
                     out_ptr     <= '0;
                     res_valid_o <= 1'b0;
                     state       <= ST_IDLE;
                  end else begin
                     out_ptr <= out_ptr + LP_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (core_done_i && (state != ST_RUN))
            err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fios_mm_seq_ctrl.sv
// Randomized bench for fios_mm_seq_ctrl with a behavioural FIOS core responder
// and a big-integer Montgomery reference.
module tb_fios_mm_seq_ctrl;
   localparam int W  = 17;
   localparam int S  = 8;
   localparam int PE = 3;
   localparam int CW = 8;
   localparam int NB = W * S;
   localparam int NW = (S + PE - 1) / PE;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i = 1'b1;
   logic          op_valid_i = 1'b0, op_ready_o;
   logic [W-1:0]  op_a_i = '0, op_b_i = '0, op_p_i = '0;
   logic [CW-1:0] cfg_sq_i = '0;
   logic          core_start_o;
   logic [PE*W-1:0] core_a_o;
   logic [W-1:0]  core_b_o, core_p_o;
   logic          core_a_shift_i = 1'b0, core_b_fetch_i = 1'b0, core_p_fetch_i = 1'b0;
   logic          core_res_push_i = 1'b0;
   logic [W-1:0]  core_res_i = '0;
   logic          core_done_i, model_done = 1'b0, test_done = 1'b0;
   logic          res_valid_o, res_ready_i = 1'b0, res_last_o, busy_o, err_o;
   logic [W-1:0]  res_word_o;

   assign core_done_i = model_done | test_done;

   fios_mm_seq_ctrl #(.WORD_W(W), .S(S), .PE_NB(PE), .CNT_W(CW)) dut (
      .clock_i(clk), .reset_i(reset_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .op_p_i(op_p_i), .cfg_sq_i(cfg_sq_i),
      .core_start_o(core_start_o), .core_a_o(core_a_o),
      .core_b_o(core_b_o), .core_p_o(core_p_o),
      .core_a_shift_i(core_a_shift_i), .core_b_fetch_i(core_b_fetch_i),
      .core_p_fetch_i(core_p_fetch_i), .core_res_push_i(core_res_push_i),
      .core_res_i(core_res_i), .core_done_i(core_done_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_word_o(res_word_o), .res_last_o(res_last_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;

   // a*b*2^-NB mod p, a,b < p, p odd
   function automatic logic [NB-1:0] mont(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic [NB-1:0] p);
      logic [NB+1:0] t = '0;
      for (int i = 0; i < NB; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, p};
         t = t >> 1;
      end
      if (t >= {2'b00, p}) t = t - {2'b00, p};
      return t[NB-1:0];
   endfunction

   function automatic logic [NB-1:0] final_of(input logic [NB-1:0] r, input logic [NB-1:0] p);
`ifdef FIOS_SEQ_FINAL_SUB_EN
      return (r >= p) ? r - p : r;
`else
      return r + (p - p);
`endif
   endfunction

   function automatic logic [NB-1:0] expect_chain(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                                  input logic [NB-1:0] p, input int sq);
      logic [NB-1:0] x = mont(a, b, p);
      for (int i = 0; i < sq; i++) x = mont(x, x, p);
      return final_of(x, p);
   endfunction

   function automatic logic [NB-1:0] rand_wide();
      logic [159:0] v;
      for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom;
      return v[NB-1:0];
   endfunction

   // ---------------- behavioural core responder ----------------
   int            c_phase = 0, c_cnt = 0, c_dly = 0, idx = 0;
   int            starts = 0, pad_bad = 0;
   int            npush = S;
   logic          ovr_en = 1'b0;
   logic [NB-1:0] ovr_val = '0;
   logic [NB-1:0] cap_a = '0, cap_b = '0, cap_p = '0, c_res = '0;
   logic [W-1:0]  lane;

   always @(negedge clk) begin
      core_a_shift_i  = 1'b0;
      core_b_fetch_i  = 1'b0;
      core_p_fetch_i  = 1'b0;
      core_res_push_i = 1'b0;
      model_done      = 1'b0;
      if (reset_i || !busy_o) begin
         c_phase = 0;
      end else begin
         case (c_phase)
            0: if (core_start_o) begin
                  starts++;
                  c_phase = 1;
                  c_cnt = 0;
               end
            1: begin
                  for (int k = 0; k < PE; k++) begin
                     idx  = c_cnt * PE + k;
                     lane = core_a_o[k*W +: W];
                     if (idx < S) cap_a[idx*W +: W] = lane;
                     else if (lane != '0) pad_bad++;
                  end
                  core_a_shift_i = 1'b1;
                  c_cnt++;
                  if (c_cnt == NW) begin c_phase = 2; c_cnt = 0; end
               end
            2: begin
                  cap_b[c_cnt*W +: W] = core_b_o;
                  cap_p[c_cnt*W +: W] = core_p_o;
                  core_b_fetch_i = 1'b1;
                  core_p_fetch_i = 1'b1;
                  c_cnt++;
                  if (c_cnt == S) begin
                     c_res   = ovr_en ? ovr_val : mont(cap_a, cap_b, cap_p);
                     c_dly   = $urandom_range(0, 3);
                     c_phase = 3;
                  end
               end
            3: if (c_dly == 0) begin c_phase = 4; c_cnt = 0; end
               else c_dly--;
            4: begin
                  core_res_push_i = 1'b1;
                  core_res_i = (c_cnt < S) ? c_res[c_cnt*W +: W] : W'($urandom);
                  c_cnt++;
                  if (c_cnt == npush) c_phase = 5;
               end
            default: begin
                  model_done = 1'b1;
                  c_phase = 0;
               end
         endcase
      end
   end

   // ---------------- host-side drivers ----------------
   task automatic load_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [NB-1:0] p, input int sq);
      int j = 0;
      int guard = 0;
      while (j < S && guard < 400) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(0, 3) == 0) begin
            op_valid_i = 1'b0;
         end else begin
            op_valid_i = 1'b1;
            op_a_i = a[j*W +: W];
            op_b_i = b[j*W +: W];
            op_p_i = p[j*W +: W];
            cfg_sq_i = (j == 0) ? CW'(sq) : CW'($urandom);
            if (op_ready_o) j++;
         end
      end
      @(negedge clk);
      op_valid_i = 1'b0;
      chk_cnt++;
      if (j != S) $display("FAIL load_beats: accepted %0d required %0d", j, S);
      else pass_cnt++;
   endtask

   task automatic collect(input int mode, input int nmax, output logic [NB-1:0] got,
                          output int n, output int nlast, output int lastpos,
                          output int stall_bad);
      int guard = 0;
      int tog = 0;
      logic rdy;
      logic prev_stall = 1'b0;
      logic [W-1:0] prev_w = '0;
      got = '0; n = 0; nlast = 0; lastpos = -1; stall_bad = 0;
      while (n < nmax && guard < 600) begin
         @(negedge clk);
         guard++;
         if (prev_stall && (!res_valid_o || res_word_o !== prev_w)) stall_bad++;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (tog % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tog++;
         res_ready_i = rdy;
         if (res_valid_o && rdy) begin
            got[n*W +: W] = res_word_o;
            if (res_last_o) begin nlast++; lastpos = n; end
            n++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = res_valid_o;
            prev_w = res_word_o;
         end
      end
   endtask

   task automatic rand_ops(output logic [NB-1:0] a, output logic [NB-1:0] b,
                           output logic [NB-1:0] p);
      p = rand_wide(); p[NB-1] = 1'b0; p[NB-2] = 1'b1; p[0] = 1'b1;
      a = rand_wide(); a[NB-1] = 1'b0; a[NB-2] = 1'b0;
      b = rand_wide(); b[NB-1] = 1'b0; b[NB-2] = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk); reset_i = 1'b1;
      @(negedge clk);
      chk_cnt++; if (op_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", op_ready_o); else pass_cnt++;
      chk_cnt++; if (core_start_o !== 1'b0) $display("FAIL rst_start: got %b want 0", core_start_o); else pass_cnt++;
      chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", res_valid_o); else pass_cnt++;
      chk_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else pass_cnt++;
      chk_cnt++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else pass_cnt++;
      reset_i = 1'b0;
      test_done = 1'b1;
      @(negedge clk);
      test_done = 1'b0;
      chk_cnt++; if (op_ready_o !== 1'b1) $display("FAIL load_ready: got %b want 1", op_ready_o); else pass_cnt++;
      chk_cnt++; if (busy_o !== 1'b1) $display("FAIL load_busy: got %b want 1", busy_o); else pass_cnt++;
      chk_cnt++; if (err_o !== 1'b1) $display("FAIL idle_done_err: got %b want 1", err_o); else pass_cnt++;
      repeat (3) @(negedge clk);
      chk_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else pass_cnt++;
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk_cnt++; if (err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o); else pass_cnt++;
   endtask

   task automatic test_multiply(input int nrand, input int mode, input bit chain);
      logic [NB-1:0] a, b, p, got, exp;
      int n, nlast, lastpos, stall_bad, s0, pb0, sq;
      for (int t = 0; t <= nrand; t++) begin
         if (t == 0) begin
            a = NB'(2); b = NB'(3); p = NB'(32'h1_0001);
            sq = chain ? 3 : 0;
         end else begin
            rand_ops(a, b, p);
            sq = chain ? $urandom_range(1, 4) : 0;
         end
         exp = expect_chain(a, b, p, sq);
         s0 = starts; pb0 = pad_bad;
         load_op(a, b, p, sq);
         collect(mode, S, got, n, nlast, lastpos, stall_bad);
         @(negedge clk); res_ready_i = 1'b0;
         chk_cnt++; if (n != S) $display("FAIL mul_count: got %0d words want %0d", n, S); else pass_cnt++;
         chk_cnt++; if (got !== exp) $display("FAIL mul_result sq=%0d: got %h want %h", sq, got, exp); else pass_cnt++;
         chk_cnt++; if (nlast != 1 || lastpos != S - 1) $display("FAIL mul_last: count %0d at %0d want 1 at %0d", nlast, lastpos, S - 1); else pass_cnt++;
         chk_cnt++; if (starts - s0 != sq + 1) $display("FAIL mul_starts: got %0d want %0d", starts - s0, sq + 1); else pass_cnt++;
         chk_cnt++; if (pad_bad != pb0) $display("FAIL mul_a_pad: got %0d nonzero pad lanes want 0", pad_bad - pb0); else pass_cnt++;
         chk_cnt++; if (stall_bad != 0) $display("FAIL mul_stall: got %0d unstable stalls want 0", stall_bad); else pass_cnt++;
         chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL mul_no_extra: valid %b want 0", res_valid_o); else pass_cnt++;
         chk_cnt++; if (err_o !== 1'b0) $display("FAIL mul_err: got %b want 0", err_o); else pass_cnt++;
      end
   endtask

   task automatic test_errors();
      logic [NB-1:0] a, b, p, got;
      int n, nlast, lastpos, stall_bad;
      rand_ops(a, b, p);
      npush = S + 1;
      load_op(a, b, p, 0);
      collect(0, S, got, n, nlast, lastpos, stall_bad);
      @(negedge clk); res_ready_i = 1'b0;
      npush = S;
      chk_cnt++; if (err_o !== 1'b1) $display("FAIL ovf_err: got %b want 1", err_o); else pass_cnt++;
      chk_cnt++; if (got !== mont(a, b, p)) $display("FAIL ovf_result: got %h want %h", got, mont(a, b, p)); else pass_cnt++;
      load_op(a, b, p, 0);
      collect(0, S, got, n, nlast, lastpos, stall_bad);
      @(negedge clk); res_ready_i = 1'b0;
      chk_cnt++; if (err_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", err_o); else pass_cnt++;
      reset_i = 1'b1; @(negedge clk); reset_i = 1'b0;
      chk_cnt++; if (err_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", err_o); else pass_cnt++;
      npush = S - 1;
      load_op(a, b, p, 0);
      collect(0, S, got, n, nlast, lastpos, stall_bad);
      @(negedge clk); res_ready_i = 1'b0;
      npush = S;
      chk_cnt++; if (err_o !== 1'b1) $display("FAIL short_err: got %b want 1", err_o); else pass_cnt++;
      chk_cnt++; if (n != S) $display("FAIL short_stream: got %0d words want %0d", n, S); else pass_cnt++;
      reset_i = 1'b1; @(negedge clk); reset_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [NB-1:0] a, b, p, got;
      int n, nlast, lastpos, stall_bad, g;
      rand_ops(a, b, p);
      load_op(a, b, p, 2);
      g = 0;
      while (c_phase != 2 && g < 300) begin @(negedge clk); g++; end
      chk_cnt++; if (c_phase != 2) $display("FAIL mid_run_reach: phase %0d want 2", c_phase); else pass_cnt++;
      reset_i = 1'b1;
      @(negedge clk);
      chk_cnt++; if (busy_o !== 1'b0) $display("FAIL mid_run_busy: got %b want 0", busy_o); else pass_cnt++;
      chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL mid_run_valid: got %b want 0", res_valid_o); else pass_cnt++;
      reset_i = 1'b0;
      repeat (20) @(negedge clk);
      chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL mid_run_noresult: got %b want 0", res_valid_o); else pass_cnt++;
      rand_ops(a, b, p);
      load_op(a, b, p, 0);
      collect(2, 3, got, n, nlast, lastpos, stall_bad);
      @(negedge clk);
      res_ready_i = 1'b0;
      reset_i = 1'b1;
      @(negedge clk);
      chk_cnt++; if (busy_o !== 1'b0) $display("FAIL mid_drain_busy: got %b want 0", busy_o); else pass_cnt++;
      chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL mid_drain_valid: got %b want 0", res_valid_o); else pass_cnt++;
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (res_valid_o !== 1'b0) $display("FAIL mid_drain_noresult: got %b want 0", res_valid_o); else pass_cnt++;
      rand_ops(a, b, p);
      load_op(a, b, p, 1);
      collect(2, S, got, n, nlast, lastpos, stall_bad);
      @(negedge clk); res_ready_i = 1'b0;
      chk_cnt++; if (got !== expect_chain(a, b, p, 1)) $display("FAIL post_reset_result: got %h want %h", got, expect_chain(a, b, p, 1)); else pass_cnt++;
   endtask

   task automatic test_final_sub();
      logic [NB-1:0] a, b, p, got, exp;
      int n, nlast, lastpos, stall_bad;
      for (int t = 0; t < 4; t++) begin
         if (t < 2) p = NB'(32'h1_0001);
         else rand_ops(a, b, p);
         a = NB'(2); b = NB'(3);
         ovr_val = (t % 2 == 0) ? p + NB'(5) : p - NB'(1);
         ovr_en = 1'b1;
         exp = final_of(ovr_val, p);
         load_op(a, b, p, 0);
         collect(2, S, got, n, nlast, lastpos, stall_bad);
         @(negedge clk); res_ready_i = 1'b0;
         ovr_en = 1'b0;
         chk_cnt++; if (got !== exp) $display("FAIL finsub_%0d: got %h want %h", t, got, exp); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_multiply(3, 2, 1'b0);
      test_multiply(2, 0, 1'b1);
      test_multiply(1, 1, 1'b1);
      test_errors();
      test_reset_mid();
      test_final_sub();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
